// File: rtl/trit_mac.sv
// Balanced-ternary multiply-accumulate: each trit product is rippled into an
// N_TRITS-trit accumulator one trit per cycle; result is held until consumed.
module trit_mac #(
  parameter int unsigned N_TRITS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             a,
  input  logic [1:0]             b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N_TRITS-1:0]   acc,
  output logic                   err,
  output logic                   ovf
);

  localparam int unsigned ACC_W = 2 * N_TRITS;
  localparam int unsigned IDX_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;

  localparam logic [1:0] T_POS  = 2'b10;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_NEG  = 2'b01;
  localparam logic [1:0] T_ERR  = 2'b11;

  typedef enum logic [1:0] {ACCEPT, CARRY, DONE} state_t;

  state_t           state, state_d;
  logic [ACC_W-1:0] acc_d;
  logic             err_d, ovf_d;
  logic [1:0]       carry, carry_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             last, last_d;

  logic             in_err;
  logic [1:0]       prod;
  logic [1:0]       cur_trit;
  logic [1:0]       new_trit;
  logic [1:0]       new_carry;

  // Trit product of the incoming pair; error codes contribute nothing.
  always_comb begin
    in_err = (a == T_ERR) || (b == T_ERR);
    prod   = T_ZERO;
    if (!in_err && (a != T_ZERO) && (b != T_ZERO)) begin
      prod = (a == b) ? T_POS : T_NEG;
    end
  end

  // One-trit add of the pending carry into the trit selected by idx.
  always_comb begin
    cur_trit = T_ZERO;
    for (int unsigned i = 0; i < N_TRITS; i++) begin
      if (idx == IDX_W'(i)) cur_trit = acc[2*i +: 2];
    end
    new_trit  = T_ZERO;
    new_carry = T_ZERO;
    if (cur_trit == T_ZERO) begin
      new_trit = carry;
    end else if (carry == T_ZERO) begin
      new_trit = cur_trit;
    end else if (cur_trit == carry) begin
      // +/-2 folds to the opposite trit with a same-signed carry out
      new_trit  = (carry == T_POS) ? T_NEG : T_POS;
      new_carry = carry;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    err_d   = err;
    ovf_d   = ovf;
    carry_d = carry;
    idx_d   = idx;
    last_d  = last;
    case (state)
      ACCEPT: begin
        if (in_valid && in_ready) begin
          if (in_err) err_d = 1'b1;
          if (prod == T_ZERO) begin
            state_d = in_last ? DONE : ACCEPT;
          end else begin
            carry_d = prod;
            idx_d   = '0;
            last_d  = in_last;
            state_d = CARRY;
          end
        end
      end
      CARRY: begin
        for (int unsigned i = 0; i < N_TRITS; i++) begin
          if (idx == IDX_W'(i)) acc_d[2*i +: 2] = new_trit;
        end
        if ((new_carry == T_ZERO) || (idx == IDX_W'(N_TRITS - 1))) begin
          // A carry out of the top trit is dropped: the sum wraps mod 3^N_TRITS
          if (new_carry != T_ZERO) ovf_d = 1'b1;
          carry_d = T_ZERO;
          idx_d   = '0;
          state_d = last ? DONE : ACCEPT;
        end else begin
          carry_d = new_carry;
          idx_d   = idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      acc       <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      carry     <= T_ZERO;
      idx       <= '0;
      last      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      err       <= err_d;
      ovf       <= ovf_d;
      carry     <= carry_d;
      idx       <= idx_d;
      last      <= last_d;
      in_ready  <= (state_d == ACCEPT);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_trit_mac.sv
// Bench for trit_mac: a 9-trit and a 2-trit instance checked against an
// integer dot-product model with wrap-around, plus directed literal cases.
`timescale 1ns/1ps
module tb_trit_mac;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      in_valid, in_last, out_ready;
  logic [1:0][1:0] a, b;
  wire  [1:0]      in_ready, out_valid, err, ovf;
  wire  [17:0]     acc9;
  wire  [3:0]      acc2;
  wire  [1:0][17:0] accv;

  int checks   = 0;
  int failures = 0;
  int msum [2];
  bit merr [2];
  bit movf [2];

  always #5 clk = ~clk;

  assign accv[0] = acc9;
  assign accv[1] = {14'b0, acc2};

  trit_mac #(.N_TRITS(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .acc(acc9), .err(err[0]), .ovf(ovf[0])
  );

  trit_mac #(.N_TRITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .acc(acc2), .err(err[1]), .ovf(ovf[1])
  );

  function automatic int ntr(input int k);
    return (k == 0) ? 9 : 2;
  endfunction

  function automatic int pow3(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 3;
    return r;
  endfunction

  function automatic int tval(input logic [1:0] t);
    return (t == 2'b10) ? 1 : ((t == 2'b01) ? -1 : 0);
  endfunction

  function automatic int dec(input logic [17:0] v, input int n);
    int s = 0;
    for (int i = n - 1; i >= 0; i--) s = s * 3 + tval(v[2*i +: 2]);
    return s;
  endfunction

  function automatic int has_err_code(input logic [17:0] v);
    for (int i = 0; i < 9; i++) if (v[2*i +: 2] == 2'b11) return 1;
    return 0;
  endfunction

  // Carry cycles: one, plus one per low-order balanced digit equal to p, capped at n.
  function automatic int exp_stall(input int s, input int p, input int n);
    int v = s;
    int l = 1;
    int r, t;
    for (int i = 0; i < n - 1; i++) begin
      r = ((v % 3) + 3) % 3;
      t = (r == 2) ? -1 : r;
      if (t != p) break;
      l++;
      v = (v - t) / 3;
    end
    return l;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model while results are presented.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("acc_no_err_code", has_err_code(accv[k]), 0);
        chk("ready_valid_exclusive", int'(in_ready[k] & out_valid[k]), 0);
        if (out_valid[k]) begin
          chk("done_acc_value", dec(accv[k], ntr(k)), msum[k]);
          chk("done_err", int'(err[k]), int'(merr[k]));
          chk("done_ovf", int'(ovf[k]), int'(movf[k]));
        end
      end
    end
  end

  task automatic handshake(input int k, input logic [1:0] ta, input logic [1:0] tb,
                           input bit last, output int exp_l);
    int p, n, m;
    bit e;
    bit got;
    n = ntr(k);
    exp_l = 0;
    @(negedge clk);
    a[k] = ta; b[k] = tb; in_last[k] = last; in_valid[k] = 1'b1;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (in_ready[k]) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("handshake_timeout", 0, 1);
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
    e = (ta == 2'b11) || (tb == 2'b11);
    p = e ? 0 : tval(ta) * tval(tb);
    exp_l = (p == 0) ? 0 : exp_stall(msum[k], p, n);
    m = (pow3(n) - 1) / 2;
    msum[k] = msum[k] + p;
    if (msum[k] > m) begin msum[k] = msum[k] - pow3(n); movf[k] = 1; end
    else if (msum[k] < -m) begin msum[k] = msum[k] + pow3(n); movf[k] = 1; end
    if (e) merr[k] = 1;
  endtask

  task automatic wait_stall(input int k, output int l);
    l = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready[k] || out_valid[k]) return;
      l++;
    end
    chk("stall_timeout", 0, 1);
  endtask

  task automatic send(input int k, input logic [1:0] ta, input logic [1:0] tb,
                      input bit last, output int l);
    int el;
    handshake(k, ta, tb, last, el);
    wait_stall(k, l);
    chk("stall_length", l, el);
  endtask

  task automatic wait_done(input int k);
    for (int c = 0; c < 200; c++) begin
      if (out_valid[k]) return;
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic consume(input int k, input int hold);
    out_ready[k] = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready[k]), 0);
      chk("hold_out_valid", int'(out_valid[k]), 1);
    end
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    msum[k] = 0; merr[k] = 0; movf[k] = 0;
    chk("clear_acc", int'(accv[k]), 0);
    chk("clear_err", int'(err[k]), 0);
    chk("clear_ovf", int'(ovf[k]), 0);
    chk("clear_in_ready", int'(in_ready[k]), 1);
    chk("clear_out_valid", int'(out_valid[k]), 0);
  endtask

  function automatic logic [1:0] pick_trit();
    int r = $urandom_range(0, 15);
    if (r == 15) return 2'b11;
    return (r % 3 == 0) ? 2'b00 : ((r % 3 == 1) ? 2'b01 : 2'b10);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, el, len;
    logic [1:0] ta, tb;
    rst = 1'b1;
    in_valid = '0; in_last = '0; out_ready = '0;
    a = '0; b = '0;
    for (int k = 0; k < 2; k++) begin msum[k] = 0; merr[k] = 0; movf[k] = 0; end

    @(posedge clk);
    #1;
    chk("reset_acc9", int'(acc9), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", int'(in_ready), 3);

    // Three +1 terms: carry lengths 1, 2, 1 and result +3.
    send(0, 2'b10, 2'b10, 1'b0, l); chk("t1_carry0", l, 1);
    send(0, 2'b10, 2'b10, 1'b0, l); chk("t1_carry1", l, 2);
    send(0, 2'b10, 2'b10, 1'b1, l); chk("t1_carry2", l, 1);
    wait_done(0);
    chk("t1_acc", int'(acc9), 18'h00008);
    chk("t1_model", msum[0], 3);
    chk("t1_err", int'(err[0]), 0);
    chk("t1_ovf", int'(ovf[0]), 0);
    chk("t1_out_valid", int'(out_valid[0]), 1);
    consume(0, 5);

    // -1 then +1 cancels.
    send(0, 2'b10, 2'b01, 1'b0, l); chk("t2_carry0", l, 1);
    send(0, 2'b01, 2'b01, 1'b1, l); chk("t2_carry1", l, 1);
    wait_done(0);
    chk("t2_acc", int'(acc9), 0);
    chk("t2_err", int'(err[0]), 0);
    chk("t2_out_valid", int'(out_valid[0]), 1);
    consume(0, 0);

    // Error code is sticky and contributes nothing.
    send(0, 2'b11, 2'b10, 1'b0, l); chk("t3_no_stall", l, 0);
    send(0, 2'b10, 2'b10, 1'b1, l);
    wait_done(0);
    chk("t3_err", int'(err[0]), 1);
    chk("t3_acc", int'(acc9), 18'h00002);
    consume(0, 1);

    // Two-trit instance: +4 then wrap to -4.
    for (int i = 0; i < 4; i++) send(1, 2'b10, 2'b10, 1'b0, l);
    chk("t4_acc_plus4", int'(acc2), 4'hA);
    send(1, 2'b10, 2'b10, 1'b1, l); chk("t4_wrap_carry", l, 2);
    wait_done(1);
    chk("t4_acc_minus4", int'(acc2), 4'h5);
    chk("t4_ovf", int'(ovf[1]), 1);
    chk("t4_model", msum[1], -4);
    consume(1, 2);

    // Reset mid-carry with ovf set abandons everything.
    for (int i = 0; i < 5; i++) send(1, 2'b10, 2'b10, 1'b0, l);
    chk("t5_pre_ovf", int'(ovf[1]), 1);
    chk("t5_pre_acc", int'(acc2), 4'h5);
    handshake(1, 2'b10, 2'b10, 1'b0, el);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_acc", int'(acc2), 0);
    chk("t5_rst_ovf", int'(ovf[1]), 0);
    chk("t5_rst_out_valid", int'(out_valid[1]), 0);
    chk("t5_rst_err", int'(err[1]), 0);
    for (int k = 0; k < 2; k++) begin msum[k] = 0; merr[k] = 0; movf[k] = 0; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_release_in_ready", int'(in_ready[1]), 1);
    chk("t5_release_out_valid", int'(out_valid[1]), 0);
    send(1, 2'b10, 2'b10, 1'b1, l); chk("t5_after_carry", l, 1);
    wait_done(1);
    chk("t5_after_acc", int'(acc2), 4'h2);
    consume(1, 0);

    // Randomized dot products on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 8; t++) begin
        len = (k == 0) ? $urandom_range(1, 30) : $urandom_range(1, 10);
        for (int j = 0; j < len; j++) begin
          ta = pick_trit();
          tb = pick_trit();
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send(k, ta, tb, j == len - 1, l);
        end
        wait_done(k);
        consume(k, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trit_mac.md
TRIT_MAC -- requirements
Module: trit_mac

Interface
REQ-001 Parameter N_TRITS, default 9; width of the balanced-ternary accumulator in trits (2*N_TRITS bits; N_TRITS >= 2).
REQ-002 Trit encoding on every trit port SHALL be: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1, 2'b11 = error. Trit k of a multi-trit bus SHALL occupy bits [2k+1:2k], with trit 0 least significant.
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  a, b and in_last are valid this cycle.
REQ-007 in_ready  out  1  block accepts a trit pair this cycle.
REQ-008 a  in  2  multiplicand trit.
REQ-009 b  in  2  multiplier trit.
REQ-010 in_last  in  1  this pair is the final term of the current dot product.
REQ-011 out_valid  out  1  acc, err and ovf hold the final result.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 acc  out  2*N_TRITS  accumulated sum in balanced ternary.
REQ-014 err  out  1  sticky: an error code (2'b11) was seen on a or b.
REQ-015 ovf  out  1  sticky: the accumulator wrapped.

Function
REQ-016 The block SHALL compute the sum of a*b over all accepted pairs up to and including the pair carrying in_last.
REQ-017 The FSM SHALL have exactly three states: ACCEPT, CARRY, DONE.
REQ-018 A handshake SHALL occur when in_valid && in_ready. in_ready SHALL be 1 only in ACCEPT. out_valid SHALL be 1 only in DONE.
REQ-019 The product p of a handshake SHALL be +1 when a == b (nonzero), -1 when a != b (both nonzero), and 0 when either operand is 0.
REQ-020 If a or b is 2'b11, the block SHALL set err, treat p as 0, and leave acc unchanged.
REQ-021 ACCEPT with p = 0: state SHALL stay ACCEPT, or go to DONE next cycle if in_last; no stall.
REQ-022 ACCEPT with p != 0: the block SHALL latch carry = p, trit index = 0 and in_last, then go to CARRY.
REQ-023 CARRY SHALL process one trit per cycle: s = acc[idx] + carry. s = +2 gives trit -1, carry +1. s = -2 gives trit +1, carry -1. Otherwise trit = s and carry = 0. idx SHALL then increment.
REQ-024 CARRY SHALL exit when the new carry is 0, going to DONE if the latched last is set, else to ACCEPT.
REQ-025 At idx = N_TRITS-1 with a nonzero new carry, the block SHALL drop the carry, set ovf and exit as in REQ-024. The result wraps modulo 3^N_TRITS.
REQ-026 Stall per nonzero term SHALL be 1..N_TRITS CARRY cycles; the next pair SHALL be accepted in the cycle after CARRY exits.
REQ-027 DONE SHALL hold acc, err and ovf stable while out_ready = 0.
REQ-028 On out_valid && out_ready, the block SHALL clear acc to all 2'b00 and clear err and ovf at that edge, and go to ACCEPT.
REQ-029 acc SHALL never contain the 2'b11 code.

Reset
REQ-030 rst = 1 SHALL immediately, without waiting for a clock edge, force state ACCEPT, acc = 0, err = 0, ovf = 0, out_valid = 0, and clear carry, idx and the latched last. in_ready SHALL be 1 after reset is released.
REQ-031 Reset asserted in CARRY or DONE SHALL abandon the operation in progress; no partial result is retained.

Verification
REQ-032 The bench SHALL drive three (10,10) pairs, last on the third. Required: CARRY lengths 1, 2, 1; acc = 18'h00008 (+3); err = 0; ovf = 0; out_valid = 1.
REQ-033 The bench SHALL drive (10,01) then (01,01) with last. Required: acc = 0, out_valid = 1, err = 0.
REQ-034 The bench SHALL drive (11,10), then (10,10) with last. Required: err = 1, acc = 18'h00002 (+1).
REQ-035 The bench SHALL instantiate N_TRITS = 2 and drive four (10,10) pairs giving acc = 4'hA (+4), then one (10,10) pair with last. Required: acc = 4'h5 (-4), ovf = 1.
REQ-036 In DONE the bench SHALL hold out_ready = 0 for 5 cycles. Required: acc stable, in_ready = 0. Then out_ready = 1: required acc, err and ovf = 0 and in_ready = 1 on the next cycle.
REQ-037 The bench SHALL assert rst mid-CARRY, between clock edges. Required: acc = 0, out_valid = 0 and ovf = 0 immediately, and state ACCEPT after release.
